// File: rtl/intr_sched.sv
// Interrupt controller/scheduler: latches peripheral event pulses, masks them with the
// W_INTR configuration, and hands one fixed-priority request at a time to the CPU.
module intr_sched #(
    parameter int N_SRC  = 4,
    parameter int ID_W   = 2,
    parameter int LOST_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_SRC-1:0]  src_pulse,
    input  logic              w_intr_en,
    input  logic [31:0]       w_intr_data,
    input  logic              iret,
    input  logic              intr_ack,
    output logic              intr_req,
    output logic [ID_W-1:0]   intr_id,
    output logic              in_service,
    output logic [N_SRC-1:0]  cfg_mask,
    output logic              cfg_gie,
    output logic [N_SRC-1:0]  pending,
    output logic [LOST_W-1:0] lost_cnt,
    output logic              spurious_iret
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t             state, state_nxt;
    logic               req_nxt, svc_nxt, lost_evt;
    logic [ID_W-1:0]    id_nxt;
    logic [N_SRC-1:0]   eligible, clr, pending_nxt;
    logic               unused_w_intr_bits;

    assign unused_w_intr_bits = ^w_intr_data[30:N_SRC];

    // Lowest set index wins: index 0 is the highest priority source.
    function automatic logic [ID_W-1:0] first_set(input logic [N_SRC-1:0] v);
        logic [ID_W-1:0] r;
        r = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) r = ID_W'(i);
        end
        return r;
    endfunction

    function automatic logic [LOST_W-1:0] sat_inc(input logic [LOST_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign eligible = cfg_gie ? (pending & cfg_mask) : '0;

    always_comb begin
        state_nxt = state;
        req_nxt   = intr_req;
        id_nxt    = intr_id;
        svc_nxt   = in_service;
        clr       = '0;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    state_nxt = REQ;
                    req_nxt   = 1'b1;
                    id_nxt    = first_set(eligible);
                end
            end
            REQ: begin
                // Ack beats a simultaneous withdrawal; the id stays frozen while requesting.
                if (intr_ack) begin
                    clr[intr_id] = 1'b1;
                    state_nxt    = SERVICE;
                    req_nxt      = 1'b0;
                    svc_nxt      = 1'b1;
                end else if (!(cfg_gie && cfg_mask[intr_id])) begin
                    state_nxt = IDLE;
                    req_nxt   = 1'b0;
                end
            end
            SERVICE: begin
                if (iret) begin
                    state_nxt = IDLE;
                    svc_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                req_nxt   = 1'b0;
                svc_nxt   = 1'b0;
            end
        endcase
        // A fresh event on the bit being acknowledged survives the clear.
        pending_nxt = (pending & ~clr) | src_pulse;
        lost_evt    = |(src_pulse & pending & ~clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            intr_req      <= 1'b0;
            intr_id       <= '0;
            in_service    <= 1'b0;
            cfg_mask      <= '0;
            cfg_gie       <= 1'b0;
            pending       <= '0;
            lost_cnt      <= '0;
            spurious_iret <= 1'b0;
        end else begin
            state      <= state_nxt;
            intr_req   <= req_nxt;
            intr_id    <= id_nxt;
            in_service <= svc_nxt;
            pending    <= pending_nxt;
            if (lost_evt) lost_cnt <= sat_inc(lost_cnt);
            if (iret && (state != SERVICE)) spurious_iret <= 1'b1;
            if (w_intr_en) begin
                cfg_mask <= w_intr_data[N_SRC-1:0];
                cfg_gie  <= w_intr_data[31];
            end
        end
    end

endmodule

// File: tb/tb_intr_sched.sv
// Bench for intr_sched: directed scenarios plus random traffic, every cycle checked
// against a reference model through an expectation queue.
module tb_intr_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  src_pulse;
    logic        w_intr_en;
    logic [31:0] w_intr_data;
    logic        iret;
    logic        intr_ack;
    logic        intr_req;
    logic [1:0]  intr_id;
    logic        in_service;
    logic [3:0]  cfg_mask;
    logic        cfg_gie;
    logic [3:0]  pending;
    logic [7:0]  lost_cnt;
    logic        spurious_iret;

    int checks = 0;
    int errors = 0;

    intr_sched #(.N_SRC(4), .ID_W(2), .LOST_W(8)) dut (
        .clk(clk), .reset(reset), .src_pulse(src_pulse), .w_intr_en(w_intr_en),
        .w_intr_data(w_intr_data), .iret(iret), .intr_ack(intr_ack),
        .intr_req(intr_req), .intr_id(intr_id), .in_service(in_service),
        .cfg_mask(cfg_mask), .cfg_gie(cfg_gie), .pending(pending),
        .lost_cnt(lost_cnt), .spurious_iret(spurious_iret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       req;
        logic [1:0] id;
        logic       svc;
        logic [3:0] mask;
        logic       gie;
        logic [3:0] pend;
        logic [7:0] lost;
        logic       spur;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Reference model: mode 0 = nothing outstanding, 1 = offering a request, 2 = handler running
    int         m_mode;
    logic [1:0] m_id;
    logic [3:0] m_pend, m_mask;
    logic       m_gie, m_spur;
    int         m_lost;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic model_step();
        exp_t       e;
        logic [3:0] offered, clr;
        logic       taken;
        int         next_mode;
        if (reset) begin
            m_mode = 0; m_id = 0; m_pend = 0; m_mask = 0; m_gie = 0; m_lost = 0; m_spur = 0;
        end else begin
            offered   = m_gie ? (m_pend & m_mask) : 4'b0;
            taken     = (m_mode == 1) && intr_ack;
            clr       = taken ? (4'b0001 << m_id) : 4'b0000;
            next_mode = m_mode;
            if (m_mode == 0) begin
                if (offered != 0) begin
                    next_mode = 1;
                    for (int i = 3; i >= 0; i--) if (offered[i]) m_id = 2'(i);
                end
            end else if (m_mode == 1) begin
                if (taken) next_mode = 2;
                else if (!(m_gie && m_mask[m_id])) next_mode = 0;
            end else if (iret) begin
                next_mode = 0;
            end
            if (iret && m_mode != 2) m_spur = 1;
            if (((src_pulse & m_pend & ~clr) != 0) && m_lost < 255) m_lost = m_lost + 1;
            m_pend = (m_pend & ~clr) | src_pulse;
            if (w_intr_en) begin
                m_mask = w_intr_data[3:0];
                m_gie  = w_intr_data[31];
            end
            m_mode = next_mode;
        end
        e.req  = (m_mode == 1);
        e.id   = m_id;
        e.svc  = (m_mode == 2);
        e.mask = m_mask;
        e.gie  = m_gie;
        e.pend = m_pend;
        e.lost = 8'(m_lost);
        e.spur = m_spur;
        sb.push_back(e);
    endtask

    // One clock: apply inputs away from the edge, record the expectation, return after the edge.
    task automatic cyc(input logic rst_i, input logic [3:0] p, input logic we,
                       input logic [31:0] wd, input logic ir, input logic ack);
        @(negedge clk);
        reset = rst_i; src_pulse = p; w_intr_en = we; w_intr_data = wd; iret = ir; intr_ack = ack;
        model_step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 4'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic wintr(input logic [31:0] d);
        cyc(1'b0, 4'b0, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic pulse(input logic [3:0] p);
        cyc(1'b0, p, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic ack();
        cyc(1'b0, 4'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic do_iret();
        cyc(1'b0, 4'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            cmp("sb_intr_req", 32'(intr_req), 32'(mon_e.req));
            cmp("sb_intr_id", 32'(intr_id), 32'(mon_e.id));
            cmp("sb_in_service", 32'(in_service), 32'(mon_e.svc));
            cmp("sb_cfg_mask", 32'(cfg_mask), 32'(mon_e.mask));
            cmp("sb_cfg_gie", 32'(cfg_gie), 32'(mon_e.gie));
            cmp("sb_pending", 32'(pending), 32'(mon_e.pend));
            cmp("sb_lost_cnt", 32'(lost_cnt), 32'(mon_e.lost));
            cmp("sb_spurious", 32'(spurious_iret), 32'(mon_e.spur));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; src_pulse = 0; w_intr_en = 0; w_intr_data = 0; iret = 0; intr_ack = 0;
        cyc(1'b1, 4'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 4'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cmp("reset_outputs", {intr_req, intr_id, in_service, cfg_mask, cfg_gie, pending,
                              lost_cnt, spurious_iret}, 32'h0);

        // Basic entry/exit with the two-cycle request latency
        wintr(32'h8000_0001);
        pulse(4'b0001);
        cmp("basic_pending", 32'(pending), 32'h1);
        cmp("basic_req_early", 32'(intr_req), 32'h0);
        idle(1);
        cmp("basic_req", 32'(intr_req), 32'h1);
        cmp("basic_id", 32'(intr_id), 32'h0);
        idle(1);
        ack();
        cmp("basic_ack_pending", 32'(pending), 32'h0);
        cmp("basic_ack_svc", 32'(in_service), 32'h1);
        cmp("basic_ack_req", 32'(intr_req), 32'h0);
        idle(3);
        do_iret();
        cmp("basic_iret_svc", 32'(in_service), 32'h0);

        // Priority and back-to-back service
        wintr(32'h8000_000F);
        pulse(4'b1010);
        idle(1);
        cmp("prio_first_id", 32'(intr_id), 32'h1);
        cmp("prio_first_req", 32'(intr_req), 32'h1);
        ack();
        do_iret();
        cmp("b2b_idle_gap", 32'(intr_req), 32'h0);
        idle(1);
        cmp("b2b_req", 32'(intr_req), 32'h1);
        cmp("b2b_id", 32'(intr_id), 32'h3);
        ack();
        do_iret();

        // Masked event held pending until the mask opens
        wintr(32'h8000_0004);
        pulse(4'b0001);
        idle(2);
        cmp("mask_pending", 32'(pending), 32'h1);
        cmp("mask_no_req", 32'(intr_req), 32'h0);
        wintr(32'h8000_0001);
        cmp("unmask_cfg_edge", 32'(intr_req), 32'h0);
        idle(1);
        cmp("unmask_req", 32'(intr_req), 32'h1);
        ack();
        do_iret();

        // Withdrawal on gie clear, then ack winning over the same config write
        wintr(32'h8000_000F);
        pulse(4'b0100);
        idle(1);
        cmp("wd_req_id", 32'(intr_id), 32'h2);
        wintr(32'h0000_0004);
        idle(1);
        cmp("wd_req_dropped", 32'(intr_req), 32'h0);
        cmp("wd_pending_kept", 32'(pending[2]), 32'h1);
        wintr(32'h8000_0004);
        idle(1);
        cmp("wd_rereq", 32'(intr_req), 32'h1);
        cyc(1'b0, 4'b0, 1'b1, 32'h0000_0004, 1'b0, 1'b1);
        cmp("ack_wins_svc", 32'(in_service), 32'h1);
        do_iret();

        // Lost-event counting and saturation
        wintr(32'h8000_0001);
        pulse(4'b0001);
        idle(1);
        ack();
        pulse(4'b0001);
        pulse(4'b0001);
        pulse(4'b0001);
        pulse(4'b1000);
        cmp("lost_two", 32'(lost_cnt), 32'h2);
        cmp("lost_pending", 32'(pending), 32'h9);
        for (int k = 0; k < 300; k++) pulse(4'b0001);
        cmp("lost_saturate", 32'(lost_cnt), 32'hFF);

        // Spurious iret, then reset during service
        do_iret();
        do_iret();
        cmp("spurious_set", 32'(spurious_iret), 32'h1);
        ack();
        cmp("spurious_sticky", 32'(spurious_iret), 32'h1);
        cmp("svc_before_reset", 32'(in_service), 32'h1);
        cyc(1'b1, 4'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cmp("reset_in_service", {intr_req, intr_id, in_service, cfg_mask, cfg_gie, pending,
                                 lost_cnt, spurious_iret}, 32'h0);

        // Random traffic including protocol abuse and occasional resets
        for (int k = 0; k < 3000; k++) begin
            logic        r_rst, r_we, r_ir, r_ack;
            logic [3:0]  r_p;
            logic [31:0] r_wd;
            r_rst = ($urandom_range(0, 299) == 0);
            r_p   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            r_we  = ($urandom_range(0, 11) == 0);
            r_wd  = $urandom;
            r_wd[31] = ($urandom_range(0, 3) != 0);
            r_ir  = ($urandom_range(0, 5) == 0);
            r_ack = ($urandom_range(0, 2) == 0);
            cyc(r_rst, r_p, r_we, r_wd, r_ir, r_ack);
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
